// File: rtl/irq_ctrl.sv
// irq_ctrl: programmable interrupt controller driving a registered IRQ vector to the CPU.
// Latency: source edge to IRQ is 4 clk edges with `IRQ_SYNC_EN (2-flop synchronizer), 3 without.
// Register port: single-cycle, no wait states; Ack one cycle after each Req, back-to-back allowed.
module irq_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int ADDR_W  = 3
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic [NUM_SRC-1:0] IrqSrc,
  input  logic               Req,
  input  logic               RW,
  input  logic [ADDR_W-1:0]  Addr,
  input  logic [31:0]        WrData,
  output logic [31:0]        RdData,
  output logic               Ack,
  output logic [NUM_SRC-1:0] IRQ
);

  localparam logic [ADDR_W-1:0] A_EN   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_PEND = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_MODE = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_POL  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_VEC  = ADDR_W'(4);

  logic [NUM_SRC-1:0] en;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] mode;
  logic [NUM_SRC-1:0] pol;
  logic [NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0] src_prev;
  logic               pol_wr_dly;

  logic [NUM_SRC-1:0] src_pol;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] pend_next;
  logic [NUM_SRC-1:0] active;
  logic [4:0]         vec_idx;
  logic [31:0]        rd_mux;
  logic               wr;

  // Only the low NUM_SRC write-data bits map to channel registers.
  logic unused_wr_hi;
  assign unused_wr_hi = ^WrData[31:NUM_SRC];

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync_meta;

  // Two-flop synchronizer for sources asynchronous to clk.
  always_ff @(posedge clk) begin
    if (reset_) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= IrqSrc;
      sync_q    <= sync_meta;
    end
  end
`else
  // Single capture stage for sources already synchronous to clk.
  always_ff @(posedge clk) begin
    if (reset_) sync_q <= '0;
    else        sync_q <= IrqSrc;
  end
`endif

  assign wr      = Req & ~RW;
  assign src_pol = sync_q ^ pol;
  // A polarity write flips src_pol without a real source edge; mask that one cycle.
  assign rise    = pol_wr_dly ? '0 : (src_pol & ~src_prev);
  assign clr     = (wr && Addr == A_PEND) ? WrData[NUM_SRC-1:0] : '0;
  assign active  = pend & en;

  // Next pending state: level channels follow the source, edge channels latch until W1C (set wins).
  always_comb begin
    pend_next = (mode & (rise | (pend & ~clr))) | (~mode & src_pol);
  end

  // Lowest-numbered active channel; scanning downward lets the lowest index win.
  always_comb begin
    vec_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) vec_idx = 5'(i);
    end
  end

  // Read mux over pre-update register state; unmapped addresses and upper bits read 0.
  always_comb begin
    rd_mux = '0;
    case (Addr)
      A_EN:    rd_mux[NUM_SRC-1:0] = en;
      A_PEND:  rd_mux[NUM_SRC-1:0] = pend;
      A_MODE:  rd_mux[NUM_SRC-1:0] = mode;
      A_POL:   rd_mux[NUM_SRC-1:0] = pol;
      A_VEC: begin
        rd_mux[31]  = |active;
        rd_mux[4:0] = vec_idx;
      end
      default: rd_mux = '0;
    endcase
  end

  // Register file, pending state, registered IRQ and access response.
  always_ff @(posedge clk) begin
    if (reset_) begin
      en         <= '0;
      pend       <= '0;
      mode       <= '0;
      pol        <= '0;
      src_prev   <= '0;
      pol_wr_dly <= 1'b0;
      IRQ        <= '0;
      RdData     <= '0;
      Ack        <= 1'b0;
    end else begin
      src_prev   <= src_pol;
      pol_wr_dly <= wr && (Addr == A_POL);
      pend       <= pend_next;
      IRQ        <= pend & en;
      Ack        <= Req;
      RdData     <= (Req && RW) ? rd_mux : '0;
      if (wr) begin
        case (Addr)
          A_EN:    en   <= WrData[NUM_SRC-1:0];
          A_MODE:  mode <= WrData[NUM_SRC-1:0];
          A_POL:   pol  <= WrData[NUM_SRC-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed test-plan scenarios plus randomized traffic,
// all compared cycle by cycle against a behavioural reference model.
// Build with or without +define+IRQ_SYNC_EN; the bench adapts its expected latency.
module tb_irq_ctrl;

  localparam int NS = 8;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  // Number of clock edges between a source sample and the value the pending logic sees.
  localparam int SYNC_DEPTH = LAT - 2;

  logic          clk = 1'b0;
  logic          reset_;
  logic [NS-1:0] irq_src;
  logic          req;
  logic          rw;
  logic [2:0]    addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data;
  logic          ack;
  logic [NS-1:0] irq;

  int n_checks = 0;
  int n_err    = 0;

  irq_ctrl #(.NUM_SRC(NS), .ADDR_W(3)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .IrqSrc (irq_src),
    .Req    (req),
    .RW     (rw),
    .Addr   (addr),
    .WrData (wr_data),
    .RdData (rd_data),
    .Ack    (ack),
    .IRQ    (irq)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [NS-1:0] m_en, m_pend, m_mode, m_pol, m_prev_lvl, m_irq;
  logic [NS-1:0] m_hist [SYNC_DEPTH];
  bit            m_pol_changed;
  bit            m_ack, m_was_wr;
  logic [31:0]   m_rd;

  function automatic logic [31:0] m_read(input logic [2:0] a);
    logic [31:0] v;
    logic [NS-1:0] act;
    v = 0;
    act = m_pend & m_en;
    case (a)
      3'd0: v = {24'd0, m_en};
      3'd1: v = {24'd0, m_pend};
      3'd2: v = {24'd0, m_mode};
      3'd3: v = {24'd0, m_pol};
      3'd4: begin
        for (int i = 0; i < NS; i++) begin
          if (act[i] && v == 0) v = 32'h8000_0000 + i;
        end
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic model_step();
    logic [NS-1:0] seen, lvl, npend;
    bit wr, edge_now, cleared;
    if (reset_) begin
      m_en = 0; m_pend = 0; m_mode = 0; m_pol = 0; m_prev_lvl = 0; m_irq = 0;
      m_pol_changed = 0; m_ack = 0; m_was_wr = 0; m_rd = 0;
      for (int k = 0; k < SYNC_DEPTH; k++) m_hist[k] = 0;
      return;
    end
    seen = m_hist[SYNC_DEPTH-1];
    lvl  = seen ^ m_pol;
    wr   = req && !rw;
    for (int i = 0; i < NS; i++) begin
      edge_now = lvl[i] && !m_prev_lvl[i] && !m_pol_changed;
      cleared  = wr && addr == 3'd1 && wr_data[i];
      if (m_mode[i]) npend[i] = edge_now || (m_pend[i] && !cleared);
      else           npend[i] = lvl[i];
    end
    m_ack    = req;
    m_was_wr = wr;
    m_rd     = (req && rw) ? m_read(addr) : 0;
    m_irq    = m_pend & m_en;
    m_pend   = npend;
    m_prev_lvl = lvl;
    m_pol_changed = wr && addr == 3'd3;
    if (wr) begin
      if (addr == 3'd0) m_en   = wr_data[NS-1:0];
      if (addr == 3'd2) m_mode = wr_data[NS-1:0];
      if (addr == 3'd3) m_pol  = wr_data[NS-1:0];
    end
    for (int k = SYNC_DEPTH - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = irq_src;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: advance the model on the edge, compare outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("irq", {24'd0, irq}, {24'd0, m_irq});
    check("ack", {31'd0, ack}, {31'd0, m_ack});
    if (!(m_ack && m_was_wr)) check("rdata", rd_data, m_rd);
  endtask

  task automatic bus(input bit r, input logic [2:0] a, input logic [31:0] d, output logic [31:0] q);
    req = 1; rw = r; addr = a; wr_data = d;
    tick();
    q = rd_data;
    req = 0; rw = 0; addr = 0; wr_data = 0;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus(0, a, d, q);
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [31:0] q);
    bus(1, a, 0, q);
  endtask

  task automatic do_reset();
    reset_ = 1;
    tick();
    tick();
    reset_ = 0;
  endtask

  // Counts edges until irq[ch] equals want (bounded), expects LAT.
  task automatic meas(input int ch, input logic want, input string tag);
    int k;
    bit found;
    k = -1;
    found = 0;
    for (int n = 1; n <= 10 && !found; n++) begin
      tick();
      if (irq[ch] === want) begin
        k = n;
        found = 1;
      end
    end
    check(tag, k, LAT);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q;
    reset_ = 1; irq_src = 0; req = 0; rw = 0; addr = 0; wr_data = 0;
    do_reset();

    // Reset state: all addresses read zero, Ack after every Req.
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a), q);
      check("rst_rd", q, 0);
      check("rst_ack", {31'd0, ack}, 1);
      check("rst_irq", {24'd0, irq}, 0);
    end

    // Level mode latency and W1C ignored on a level channel.
    wr_reg(3'd0, 32'h01);
    irq_src[0] = 1;
    meas(0, 1'b1, "lvl_rise_lat");
    wr_reg(3'd1, 32'h01);
    rd_reg(3'd1, q);
    check("lvl_w1c_ignored", q, 32'h01);
    irq_src[0] = 0;
    meas(0, 1'b0, "lvl_fall_lat");

    // Edge mode: 1-cycle pulse latches, W1C clears, rise on the W1C edge wins.
    wr_reg(3'd2, 32'h04);
    wr_reg(3'd0, 32'h04);
    irq_src[2] = 1;
    tick();
    irq_src[2] = 0;
    repeat (LAT + 2) tick();
    rd_reg(3'd1, q);
    check("edge_pend", q, 32'h04);
    check("edge_irq", {24'd0, irq}, 32'h04);
    wr_reg(3'd1, 32'h04);
    tick();
    check("edge_irq_clr", {24'd0, irq}, 0);
    rd_reg(3'd1, q);
    check("edge_pend_clr", q, 0);
    irq_src[2] = 1;
    repeat (LAT - 2) tick();
    wr_reg(3'd1, 32'h04);
    rd_reg(3'd1, q);
    check("edge_set_wins", q, 32'h04);
    irq_src[2] = 0;
    wr_reg(3'd1, 32'h04);

    // Polarity: switching to active-low while the source is low must not set pending.
    wr_reg(3'd2, 32'h02);
    wr_reg(3'd3, 32'h02);
    repeat (LAT + 1) tick();
    rd_reg(3'd1, q);
    check("pol_no_spurious", q & 32'h02, 0);
    irq_src[1] = 1;
    repeat (LAT + 1) tick();
    rd_reg(3'd1, q);
    check("pol_rise_ignored", q & 32'h02, 0);
    irq_src[1] = 0;
    repeat (LAT + 1) tick();
    rd_reg(3'd1, q);
    check("pol_fall_sets", q & 32'h02, 32'h02);

    // VECTOR: lowest active channel index.
    wr_reg(3'd3, 32'h00);
    wr_reg(3'd2, 32'h28);
    wr_reg(3'd0, 32'hFF);
    irq_src = 8'h28;
    tick();
    irq_src = 0;
    repeat (LAT + 1) tick();
    rd_reg(3'd4, q);
    check("vec_3", q, 32'h8000_0003);
    wr_reg(3'd1, 32'h08);
    rd_reg(3'd4, q);
    check("vec_5", q, 32'h8000_0005);
    wr_reg(3'd1, 32'h20);
    rd_reg(3'd4, q);
    check("vec_none", q, 32'h0);

    // Reset in the middle of an access with everything pending.
    wr_reg(3'd2, 32'hFF);
    irq_src = 8'hFF;
    tick();
    irq_src = 0;
    repeat (LAT + 1) tick();
    check("pre_rst_irq", {24'd0, irq}, 32'hFF);
    reset_ = 1; req = 1; rw = 1; addr = 3'd1;
    tick();
    check("midrst_ack", {31'd0, ack}, 0);
    check("midrst_irq", {24'd0, irq}, 0);
    reset_ = 0; req = 0; rw = 0; addr = 0;
    for (int a = 0; a < 5; a++) begin
      rd_reg(3'(a), q);
      check("post_rst_rd", q, 0);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      reset_  = ($urandom_range(0, 199) == 0);
      req     = $urandom_range(0, 1);
      rw      = $urandom_range(0, 1);
      addr    = 3'($urandom_range(0, 7));
      wr_data = $urandom;
      if ($urandom_range(0, 2) == 0) irq_src = irq_src ^ NS'($urandom & $urandom);
      tick();
    end
    reset_ = 0; req = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
